// File: rtl/pb_cond_pkg.sv
// Shared definitions for the push-button conditioning stage.
//   - Button index map for the mode-select and limit-control buttons.
//   - Types for the pattern-select and divider-limit values.
//   - Default limit reset, step and saturation values.
package pb_cond_pkg;

  // Signed ints so that descending loops over the mode range terminate.
  localparam int PB_MODE_LO = 0;
  localparam int PB_MODE_HI = 7;
  localparam int PB_LIM_INC = 8;
  localparam int PB_LIM_DEC = 11;

  typedef logic [2:0] mode_t;
  typedef logic [7:0] lim_t;

  localparam lim_t LIM_RESET_DEF = 8'd2;
  localparam lim_t LIM_STEP_DEF  = 8'd2;
  localparam lim_t LIM_MAX_DEF   = 8'd20;

endpackage

// File: rtl/pb_debounce.sv
// Single-button conditioner: two-flop synchronizer, debounce counter and press pulse.
// Ports:
//   clk_i    system clock
//   rst_ni   synchronous active-low reset
//   pb_i     raw asynchronous button line
//   level_o  debounced level, changes after DB_CYCLES consecutive differing samples
//   press_o  one-cycle pulse in the first cycle level_o reads 1
module pb_debounce #(
  parameter int unsigned DB_CYCLES = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pb_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CntW = $clog2(DB_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DB_CYCLES - 1);

  logic            s1_q, s2_q;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      level_d = s2_q;
      cnt_d   = '0;
      // Pulse lands in the same cycle the new high level becomes visible.
      press_d = s2_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= pb_i;
      s2_q    <= s1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/pb_conditioner.sv
// Push-button input conditioner feeding the idle-animation logic.
// Synchronizes and debounces every button, then turns presses into a 3-bit pattern select
// and an 8-bit saturating clock-divider limit.
// Ports:
//   hz100        system clock
//   reset        synchronous active-low reset
//   pb           raw asynchronous button lines
//   pb_level     debounced button levels
//   pb_press     one-cycle pulse on each debounced 0->1 transition
//   mode         selected animation pattern (lowest pressed of pb[7:0])
//   mode_strobe  one-cycle pulse when mode is written
//   lim          divider limit, stepped up by pb[8] and down by pb[11]
//   lim_strobe   one-cycle pulse when lim changes value
// Build option:
//   AUTOREPEAT_EN  holding pb[8]/pb[11] generates repeated inc/dec events
module pb_conditioner
  import pb_cond_pkg::*;
#(
  parameter int unsigned NUM_PB        = 21,
  parameter int unsigned DB_CYCLES     = 3,
  parameter lim_t        LIM_RESET     = LIM_RESET_DEF,
  parameter lim_t        LIM_STEP      = LIM_STEP_DEF,
  parameter lim_t        LIM_MAX       = LIM_MAX_DEF,
  parameter int unsigned REPEAT_DELAY  = 50,
  parameter int unsigned REPEAT_PERIOD = 10
) (
  input  logic              hz100,
  input  logic              reset,
  input  logic [NUM_PB-1:0] pb,
  output logic [NUM_PB-1:0] pb_level,
  output logic [NUM_PB-1:0] pb_press,
  output mode_t             mode,
  output logic              mode_strobe,
  output lim_t              lim,
  output logic              lim_strobe
);

  // Largest lim that can still take a full step without passing LIM_MAX.
  localparam lim_t LimIncTop = LIM_MAX - LIM_STEP;

  // Per-button synchronizer and debouncer.
  for (genvar g = 0; g < NUM_PB; g++) begin : g_pb
    pb_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_debounce (
      .clk_i  (hz100),
      .rst_ni (reset),
      .pb_i   (pb[g]),
      .level_o(pb_level[g]),
      .press_o(pb_press[g])
    );
  end

  // Repeat events for {dec, inc}.
  logic [1:0] rep_fire;

`ifdef AUTOREPEAT_EN
  localparam int unsigned HoldMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned HoldW   = $clog2(HoldMax + 1);
  localparam logic [HoldW-1:0] HoldDelay  = HoldW'(REPEAT_DELAY);
  localparam logic [HoldW-1:0] HoldPeriod = HoldW'(REPEAT_PERIOD);

  logic [1:0]            rep_level, rep_press;
  logic [1:0]            started_q, started_d;
  logic [1:0][HoldW-1:0] hold_q, hold_d;

  assign rep_level = {pb_level[PB_LIM_DEC], pb_level[PB_LIM_INC]};
  assign rep_press = {pb_press[PB_LIM_DEC], pb_press[PB_LIM_INC]};

  // hold_q counts cycles since the press (or since the last repeat); zero means idle.
  // started_q selects the initial delay versus the steady repeat period.
  always_comb begin
    rep_fire  = '0;
    hold_d    = hold_q;
    started_d = started_q;
    for (int b = 0; b < 2; b++) begin
      rep_fire[b] = rep_level[b] && (hold_q[b] == (started_q[b] ? HoldPeriod : HoldDelay));
      if (!rep_level[b]) begin
        hold_d[b]    = '0;
        started_d[b] = 1'b0;
      end else if (rep_press[b]) begin
        hold_d[b]    = HoldW'(1);
        started_d[b] = 1'b0;
      end else if (rep_fire[b]) begin
        hold_d[b]    = HoldW'(1);
        started_d[b] = 1'b1;
      end else if (hold_q[b] != '0) begin
        hold_d[b] = hold_q[b] + HoldW'(1);
      end
    end
  end

  always_ff @(posedge hz100) begin
    if (!reset) begin
      hold_q    <= '0;
      started_q <= '0;
    end else begin
      hold_q    <= hold_d;
      started_q <= started_d;
    end
  end
`else
  logic unused_repeat;
  assign unused_repeat = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign rep_fire      = '0;
`endif

  logic  inc, dec;
  mode_t mode_q, mode_d;
  logic  mode_strobe_q, mode_strobe_d;
  lim_t  lim_q, lim_d;
  logic  lim_strobe_q, lim_strobe_d;

  assign inc = pb_press[PB_LIM_INC] | rep_fire[0];
  assign dec = pb_press[PB_LIM_DEC] | rep_fire[1];

  // Priority encoder: descending scan so the lowest pressed index wins.
  always_comb begin
    mode_d        = mode_q;
    mode_strobe_d = 1'b0;
    for (int i = PB_MODE_HI; i >= PB_MODE_LO; i--) begin
      if (pb_press[i]) begin
        mode_d        = mode_t'(i);
        mode_strobe_d = 1'b1;
      end
    end
  end

  // Saturating step; simultaneous inc and dec cancel.
  always_comb begin
    lim_d = lim_q;
    if (inc && !dec) begin
      lim_d = (lim_q > LimIncTop) ? LIM_MAX : lim_q + LIM_STEP;
    end else if (dec && !inc) begin
      lim_d = (lim_q < LIM_STEP) ? '0 : lim_q - LIM_STEP;
    end
    lim_strobe_d = (lim_d != lim_q);
  end

  always_ff @(posedge hz100) begin
    if (!reset) begin
      mode_q        <= '0;
      mode_strobe_q <= 1'b0;
      lim_q         <= LIM_RESET;
      lim_strobe_q  <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      mode_strobe_q <= mode_strobe_d;
      lim_q         <= lim_d;
      lim_strobe_q  <= lim_strobe_d;
    end
  end

  assign mode        = mode_q;
  assign mode_strobe = mode_strobe_q;
  assign lim         = lim_q;
  assign lim_strobe  = lim_strobe_q;

endmodule
